branch_sequencer: RTL

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/branch_sequencer.sv
// Branch sequencer for a LEGv8 datapath: B, BL, CBZ/CBNZ, BR and (optionally) B.cond.
// Define BRANCH_SEQUENCER_COND_EN to enable B.cond; otherwise B.cond decodes as illegal.
//
// state  | meaning
// IDLE   | waiting for start; control word parked
// LINK   | BL: write PC into LINK_REG
// EVAL   | CBZ/CBNZ zero test, or B.cond flag test
// BRANCH | PC <- PC+4+K*4, done/taken
// BRREG  | PC <- Rn via A bus, done/taken
// FALL   | condition false: PC <- PC+4, done
// BAD    | unsupported opcode: PC <- PC+4, done/illegal
module branch_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int LINK_REG   = 30
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           instruction,
  input  logic [3:0]            status,
  input  logic                  zero,
  output logic [30:0]           controlWord,
  output logic [DATA_WIDTH-1:0] K,
  output logic                  busy,
  output logic                  done,
  output logic                  taken,
  output logic                  illegal
);

  typedef enum logic [2:0] {IDLE, LINK, EVAL, BRANCH, BRREG, FALL, BAD} state_t;

  state_t      state, state_nx;
  logic [31:0] ir;

  function automatic logic is_b(input logic [31:0] w);
    return w[31:26] == 6'b000101;
  endfunction
  function automatic logic is_bl(input logic [31:0] w);
    return w[31:26] == 6'b100101;
  endfunction
  function automatic logic is_cb(input logic [31:0] w);
    return w[31:25] == 7'b1011010;
  endfunction
  function automatic logic is_bcond(input logic [31:0] w);
    return w[31:24] == 8'b01010100;
  endfunction
  function automatic logic is_br(input logic [31:0] w);
    return w[31:21] == 11'b11010110000;
  endfunction

`ifdef BRANCH_SEQUENCER_COND_EN
  // ARM condition table over {N,Z,C,V}; odd codes invert, except 1111 which is always.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cf;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cf & ~z;
      3'd5:    r = (n == v);
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'b111) r = ~r;
    return r;
  endfunction
`else
  logic unused_status;
  assign unused_status = ^status;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) ir <= instruction;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_b(instruction))          state_nx = BRANCH;
          else if (is_bl(instruction))    state_nx = LINK;
          else if (is_cb(instruction))    state_nx = EVAL;
          else if (is_br(instruction))    state_nx = BRREG;
`ifdef BRANCH_SEQUENCER_COND_EN
          else if (is_bcond(instruction)) state_nx = EVAL;
`endif
          else                            state_nx = BAD;
        end
      end
      LINK: state_nx = BRANCH;
      EVAL: begin
`ifdef BRANCH_SEQUENCER_COND_EN
        if (!is_cb(ir))
          state_nx = cond_pass(ir[3:0], status) ? BRANCH : FALL;
        else
`endif
          state_nx = (zero ^ ir[24]) ? BRANCH : FALL;
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [1:0] psel;
  logic [4:0] da, sa, sb, fsel;
  logic       regw, en_alu, en_pc, pcsel;

  always_comb begin
    psel    = 2'b00;
    da      = 5'd31;
    sa      = 5'd31;
    sb      = 5'd31;
    fsel    = 5'd0;
    regw    = 1'b0;
    en_alu  = 1'b0;
    en_pc   = 1'b0;
    pcsel   = 1'b0;
    done    = 1'b0;
    taken   = 1'b0;
    illegal = 1'b0;
    K       = '0;
    busy    = (state != IDLE);
    case (state)
      LINK: begin
        da    = 5'(LINK_REG);
        regw  = 1'b1;
        en_pc = 1'b1;
      end
      EVAL: begin
        if (is_cb(ir)) begin
          sa     = ir[4:0];
          fsel   = 5'b01000;
          en_alu = 1'b1;
        end
      end
      BRANCH: begin
        psel  = 2'b11;
        pcsel = 1'b1;
        done  = 1'b1;
        taken = 1'b1;
      end
      BRREG: begin
        sa    = ir[9:5];
        psel  = 2'b10;
        done  = 1'b1;
        taken = 1'b1;
      end
      FALL: begin
        psel = 2'b01;
        done = 1'b1;
      end
      BAD: begin
        psel    = 2'b01;
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
    // Offset is only meaningful while a branch instruction is in flight.
    if (state != IDLE && state != BAD) begin
      if (is_b(ir) || is_bl(ir))
        K = {{(DATA_WIDTH-26){ir[25]}}, ir[25:0]};
      else if (is_cb(ir) || is_bcond(ir))
        K = {{(DATA_WIDTH-19){ir[23]}}, ir[23:5]};
    end
  end

  assign controlWord = {psel, da, sa, sb, fsel, regw, 1'b0, 1'b0, en_alu, 1'b0,
                        en_pc, 1'b0, pcsel, 1'b0};

endmodule
